// File: rtl/run_ctrl.sv
// run_ctrl: loads a program into instruction memory, starts the core and times the run until halt.
// Define RUN_CTRL_WATCHDOG_EN to abort runs that reach WATCHDOG_LIMIT cycles.
module run_ctrl #(
    parameter int INST_W = 10,
    parameter int ADDR_W = 8,
    parameter int CNT_W = 16,
    parameter logic [CNT_W-1:0] WATCHDOG_LIMIT = 16'd4000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              LoadValid,
    output logic              LoadReady,
    input  logic [INST_W-1:0] LoadWord,
    input  logic              LoadLast,
    input  logic              Go,
    input  logic              Halt,
    output logic              ImemWe,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [INST_W-1:0] ImemData,
    output logic              CoreStart,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              TimedOut
);
    typedef enum logic [2:0] {IDLE, LOADED, INIT, RUN, DONE} state_t;
    state_t state;
    logic [ADDR_W-1:0] ptr;
    logic accept, full;
    assign LoadReady = state == IDLE || state == DONE;
    assign accept = LoadValid & LoadReady;
    assign full = &ptr;
`ifndef RUN_CTRL_WATCHDOG_EN
    assign TimedOut = 1'b0;
`endif
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= '0;
            ImemWe <= 1'b0;
            ImemAddr <= '0;
            ImemData <= '0;
            CoreStart <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
            CycleCount <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            TimedOut <= 1'b0;
`endif
        end else begin
            ImemWe <= accept;
            CoreStart <= 1'b0;
            if (accept) begin
                ImemAddr <= ptr;
                ImemData <= LoadWord;
                if (!full) ptr <= ptr + ADDR_W'(1);
            end
            case (state)
                IDLE, LOADED, DONE:
                    // Go outranks a simultaneous load; the word is still written above
                    if (Go) begin
                        state <= INIT;
                        CoreStart <= 1'b1;
                        Busy <= 1'b1;
                        Done <= 1'b0;
                        CycleCount <= '0;
                        ptr <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                        TimedOut <= 1'b0;
`endif
                    end else if (accept) begin
                        state <= (LoadLast || full) ? LOADED : IDLE;
                        Done <= 1'b0;
                    end
                INIT: state <= RUN;
                RUN:
                    if (Halt) begin
                        state <= DONE;
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end
`ifdef RUN_CTRL_WATCHDOG_EN
                    else if (CycleCount == WATCHDOG_LIMIT) begin
                        state <= DONE;
                        Busy <= 1'b0;
                        Done <= 1'b1;
                        TimedOut <= 1'b1;
                    end
`endif
                    else if (~&CycleCount) CycleCount <= CycleCount + CNT_W'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios plus a randomized run checked against a behavioural model.
module tb_run_ctrl;
    localparam int WD = 50;
    logic CLK = 1'b0;
    logic Reset = 1'b0;
    logic LoadValid = 1'b0, LoadLast = 1'b0, Go = 1'b0, Halt = 1'b0;
    logic [9:0] LoadWord = '0;
    logic LoadReady, ImemWe, CoreStart, Busy, Done, TimedOut;
    logic [7:0] ImemAddr;
    logic [9:0] ImemData;
    logic [15:0] CycleCount;
    int errors = 0;
    int checks = 0;

    run_ctrl #(.INST_W(10), .ADDR_W(8), .CNT_W(16), .WATCHDOG_LIMIT(16'd50)) dut (
        .CLK(CLK), .Reset(Reset), .LoadValid(LoadValid), .LoadReady(LoadReady),
        .LoadWord(LoadWord), .LoadLast(LoadLast), .Go(Go), .Halt(Halt),
        .ImemWe(ImemWe), .ImemAddr(ImemAddr), .ImemData(ImemData),
        .CoreStart(CoreStart), .Busy(Busy), .Done(Done),
        .CycleCount(CycleCount), .TimedOut(TimedOut)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        LoadValid = 0; LoadLast = 0; Go = 0; Halt = 0;
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({ImemWe, ImemAddr, ImemData, CoreStart, Busy, Done, CycleCount, TimedOut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h start=%b busy=%b done=%b cnt=%0d to=%b, required all 0",
                     ImemWe, ImemAddr, ImemData, CoreStart, Busy, Done, CycleCount, TimedOut);
        end
        checks++;
        if (LoadReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", LoadReady); end
    endtask

    task automatic test_load3;
        logic [9:0] w [3];
        w[0] = 10'h001; w[1] = 10'h2AB; w[2] = 10'h3FF;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            LoadValid = 1; LoadWord = w[i]; LoadLast = (i == 2);
            tick();
            checks++;
            if (ImemWe !== 1'b1 || ImemAddr !== 8'(i) || ImemData !== w[i]) begin
                errors++;
                $display("FAIL load3_write%0d: we=%b addr=%h data=%h required 1 %h %h", i, ImemWe, ImemAddr, ImemData, 8'(i), w[i]);
            end
        end
        LoadValid = 0; LoadLast = 0;
        checks++;
        if (LoadReady !== 1'b0) begin errors++; $display("FAIL load3_ready: got %b required 0", LoadReady); end
        tick();
        checks++;
        if (ImemWe !== 1'b0 || LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL load3_loaded: we=%b ready=%b required 0 0", ImemWe, LoadReady);
        end
    endtask

    task automatic test_run(input int k);
        int pulses = 0;
        Go = 1;
        tick();
        Go = 0;
        checks++;
        if (CoreStart !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 || CycleCount !== 16'd0) begin
            errors++;
            $display("FAIL run_init: start=%b busy=%b done=%b cnt=%0d required 1 1 0 0", CoreStart, Busy, Done, CycleCount);
        end
        tick();
        for (int j = 0; j < k; j++) begin
            if (CoreStart) pulses++;
            tick();
        end
        Halt = 1;
        tick();
        Halt = 0;
        checks++;
        if (pulses != 0 || CoreStart !== 1'b0) begin
            errors++;
            $display("FAIL run_start_pulse: extra pulses=%0d start=%b required 0 0", pulses, CoreStart);
        end
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || CycleCount !== 16'(k) || TimedOut !== 1'b0) begin
            errors++;
            $display("FAIL run_done: done=%b busy=%b cnt=%0d to=%b required 1 0 %0d 0", Done, Busy, CycleCount, TimedOut, k);
        end
        Halt = 1;
        tick();
        Halt = 0;
        checks++;
        if (Done !== 1'b1 || CycleCount !== 16'(k) || LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: done=%b cnt=%0d ready=%b required 1 %0d 1", Done, CycleCount, LoadReady, k);
        end
    endtask

    task automatic test_full;
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = 10'($urandom_range(0, 1023));
            LoadValid = 1; LoadWord = w; LoadLast = 0;
            tick();
            checks++;
            if (ImemWe !== 1'b1 || ImemAddr !== 8'(i) || ImemData !== w) begin
                errors++;
                $display("FAIL full_write%0d: we=%b addr=%h data=%h required 1 %h %h", i, ImemWe, ImemAddr, ImemData, 8'(i), w);
            end
        end
        checks++;
        if (LoadReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", LoadReady); end
        tick();
        LoadValid = 0;
        checks++;
        if (ImemWe !== 1'b0) begin errors++; $display("FAIL full_257th: we=%b required 0", ImemWe); end
    endtask

    task automatic test_done_rerun;
        test_run(20);
        test_run($urandom_range(1, 40));
        LoadValid = 1; LoadWord = 10'h155; LoadLast = 0;
        tick();
        checks++;
        if (ImemWe !== 1'b1 || ImemAddr !== 8'd0 || ImemData !== 10'h155 || Done !== 1'b0 || LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL done_load0: we=%b addr=%h data=%h done=%b ready=%b required 1 00 155 0 1",
                     ImemWe, ImemAddr, ImemData, Done, LoadReady);
        end
        LoadWord = 10'h0AA; LoadLast = 1;
        tick();
        LoadValid = 0; LoadLast = 0;
        checks++;
        if (ImemWe !== 1'b1 || ImemAddr !== 8'd1 || ImemData !== 10'h0AA || LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL done_load1: we=%b addr=%h data=%h ready=%b required 1 01 0aa 0", ImemWe, ImemAddr, ImemData, LoadReady);
        end
    endtask

    task automatic test_go_accept;
        do_reset();
        LoadValid = 1; LoadWord = 10'h3C3; LoadLast = 1; Go = 1;
        tick();
        LoadValid = 0; LoadLast = 0; Go = 0;
        checks++;
        if (ImemWe !== 1'b1 || ImemAddr !== 8'd0 || ImemData !== 10'h3C3 || CoreStart !== 1'b1 || LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL go_accept: we=%b addr=%h data=%h start=%b ready=%b required 1 00 3c3 1 0",
                     ImemWe, ImemAddr, ImemData, CoreStart, LoadReady);
        end
    endtask

    task automatic test_reset_midrun;
        do_reset();
        Go = 1;
        tick();
        Go = 0;
        tick();
        repeat (7) tick();
        checks++;
        if (CycleCount !== 16'd7 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_count: cnt=%0d busy=%b required 7 1", CycleCount, Busy);
        end
        #2 Reset = 1;
        #1;
        checks++;
        if ({ImemWe, ImemAddr, ImemData, CoreStart, Busy, Done, CycleCount, TimedOut} !== '0 || LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b cnt=%0d ready=%b required 0 0 0 1", Busy, Done, CycleCount, LoadReady);
        end
        tick();
        Reset = 0;
    endtask

    task automatic test_watchdog;
        do_reset();
        Go = 1;
        tick();
        Go = 0;
        repeat (WD + 10) tick();
        checks++;
`ifdef RUN_CTRL_WATCHDOG_EN
        if (Done !== 1'b1 || TimedOut !== 1'b1 || CycleCount !== 16'(WD)) begin
            errors++;
            $display("FAIL watchdog: done=%b to=%b cnt=%0d required 1 1 %0d", Done, TimedOut, CycleCount, WD);
        end
`else
        if (Busy !== 1'b1 || TimedOut !== 1'b0 || CycleCount !== 16'(WD + 9)) begin
            errors++;
            $display("FAIL no_watchdog: busy=%b to=%b cnt=%0d required 1 0 %0d", Busy, TimedOut, CycleCount, WD + 9);
        end
`endif
    endtask

    // Behavioural model: phase 0 idle, 1 loaded, 2 starting, 3 running, 4 finished
    int m_phase, m_ptr, m_cnt;
    logic m_we, m_start, m_to;
    logic [7:0] m_addr;
    logic [9:0] m_data;

    task automatic model_edge;
        bit acc;
        int p0;
        acc = LoadValid && (m_phase == 0 || m_phase == 4);
        p0 = m_ptr;
        m_we = acc;
        m_start = 0;
        if (acc) begin
            m_addr = 8'(m_ptr);
            m_data = LoadWord;
            if (m_ptr < 255) m_ptr++;
        end
        if (m_phase == 0 || m_phase == 1 || m_phase == 4) begin
            if (Go) begin
                m_phase = 2; m_start = 1; m_cnt = 0; m_ptr = 0; m_to = 0;
            end else if (acc) m_phase = (LoadLast || p0 == 255) ? 1 : 0;
        end else if (m_phase == 2) m_phase = 3;
        else if (Halt) m_phase = 4;
`ifdef RUN_CTRL_WATCHDOG_EN
        else if (m_cnt == WD) begin m_phase = 4; m_to = 1; end
`endif
        else if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic test_random;
        logic [21:0] exp_v, got_v;
        do_reset();
        m_phase = 0; m_ptr = 0; m_cnt = 0; m_we = 0; m_start = 0; m_to = 0; m_addr = 0; m_data = 0;
        for (int c = 0; c < 800; c++) begin
            LoadValid = 1'($urandom_range(0, 1));
            LoadLast = ($urandom_range(0, 7) == 0);
            LoadWord = 10'($urandom_range(0, 1023));
            Go = ($urandom_range(0, 11) == 0);
            Halt = ($urandom_range(0, 5) == 0);
            model_edge();
            tick();
            exp_v = {m_phase == 0 || m_phase == 4, m_we, m_start, m_phase == 2 || m_phase == 3, m_phase == 4, m_to, 16'(m_cnt)};
            got_v = {LoadReady, ImemWe, CoreStart, Busy, Done, TimedOut, CycleCount};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_ctl cycle %0d: got ready/we/start/busy/done/to/cnt=%h required %h", c, got_v, exp_v);
            end
            if (m_we) begin
                checks++;
                if (ImemAddr !== m_addr || ImemData !== m_data) begin
                    errors++;
                    $display("FAIL random_write cycle %0d: addr=%h data=%h required %h %h", c, ImemAddr, ImemData, m_addr, m_data);
                end
            end
        end
        LoadValid = 0; LoadLast = 0; Go = 0; Halt = 0;
    endtask

    initial begin
        test_reset();
        test_load3();
        test_run(20);
        test_full();
        test_done_rerun();
        test_go_accept();
        test_reset_midrun();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
